// File: rtl/dmem_pipe_if.sv
// Request/response bus between the MEM stage and dmem_pipe.
interface dmem_pipe_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault
  );
endinterface

// File: rtl/dmem_pipe.sv
// Word-organised data RAM with funct3 byte/half/word access, a READ_LAT-deep
// response pipeline, self-clearing after reset and a saturating fault counter.
module dmem_pipe #(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned READ_LAT = 1,
  parameter int unsigned FCNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  dmem_pipe_if.slave        bus,
  output logic [FCNT_W-1:0] fault_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e      state_q, state_d;
  logic [AW-1:0] init_idx_q, init_idx_d;
  logic        req_ready_q, req_ready_d;

  logic [31:0] mem_q [DEPTH];

  logic        accept;
  logic [AW-1:0] word_idx;
  logic        range_err, f3_err, align_err, fault;
  logic [31:0] rd_word;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data, s0_rdata;

  logic        wr_en;
  logic [AW-1:0] wr_idx;
  logic [31:0] wr_data, wr_mask;
  logic [31:0] st_data, st_mask;

  logic [READ_LAT-1:0] pv_q, pv_d;
  logic [READ_LAT-1:0] pf_q, pf_d;
  logic [31:0]         prd_q [READ_LAT];
  logic [31:0]         prd_d [READ_LAT];

  logic [FCNT_W-1:0] fault_cnt_q, fault_cnt_d;

  // FSM next state: INIT walks init_idx across the array, then RUN until reset.
  always_comb begin
    state_d     = state_q;
    init_idx_d  = init_idx_q;
    req_ready_d = req_ready_q;
    case (state_q)
      StInit: begin
        init_idx_d = init_idx_q + 1'b1;
        if (init_idx_q == AW'(DEPTH - 1)) begin
          state_d     = StRun;
          init_idx_d  = '0;
          req_ready_d = 1'b1;
        end
      end
      StRun: begin
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = StInit;
        init_idx_d  = '0;
        req_ready_d = 1'b0;
      end
    endcase
  end

  // FSM state and registered ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StInit;
      init_idx_q  <= '0;
      req_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_idx_q  <= init_idx_d;
      req_ready_q <= req_ready_d;
    end
  end

  assign accept   = bus.req_valid & req_ready_q;
  assign word_idx = bus.req_addr[AW+1:2];
  // Compare the full word index so high address bits cannot alias into the array.
  assign range_err = ({2'b00, bus.req_addr[31:2]} >= DEPTH);

  // funct3 legality and alignment decode.
  always_comb begin
    f3_err    = 1'b0;
    align_err = 1'b0;
    case (bus.req_funct3)
      3'b000: ;
      3'b001: align_err = bus.req_addr[0];
      3'b010: align_err = |bus.req_addr[1:0];
      3'b100: f3_err = bus.req_we;
      3'b101: begin
        f3_err    = bus.req_we;
        align_err = bus.req_addr[0];
      end
      default: f3_err = 1'b1;
    endcase
  end

  assign fault   = range_err | f3_err | align_err;
  assign rd_word = mem_q[word_idx];

  // Load lane select and sign/zero extension.
  always_comb begin
    ld_byte = 8'h00;
    case (bus.req_addr[1:0])
      2'd0: ld_byte = rd_word[7:0];
      2'd1: ld_byte = rd_word[15:8];
      2'd2: ld_byte = rd_word[23:16];
      2'd3: ld_byte = rd_word[31:24];
      default: ld_byte = 8'h00;
    endcase
    ld_half = bus.req_addr[1] ? rd_word[31:16] : rd_word[15:0];
    ld_data = 32'h0;
    case (bus.req_funct3)
      3'b000: ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001: ld_data = {{16{ld_half[15]}}, ld_half};
      3'b010: ld_data = rd_word;
      3'b100: ld_data = {24'h0, ld_byte};
      3'b101: ld_data = {16'h0, ld_half};
      default: ld_data = 32'h0;
    endcase
    s0_rdata = (accept && !bus.req_we && !fault) ? ld_data : 32'h0;
  end

  // Store lane replication and byte mask.
  always_comb begin
    st_data = 32'h0;
    st_mask = 32'h0;
    case (bus.req_funct3)
      3'b000: begin
        st_data = {4{bus.req_wdata[7:0]}};
        st_mask = 32'h0000_00FF << {bus.req_addr[1:0], 3'b000};
      end
      3'b001: begin
        st_data = {2{bus.req_wdata[15:0]}};
        st_mask = bus.req_addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      end
      3'b010: begin
        st_data = bus.req_wdata;
        st_mask = 32'hFFFF_FFFF;
      end
      default: begin
        st_data = 32'h0;
        st_mask = 32'h0;
      end
    endcase
  end

  // Single write port: INIT clearing or an accepted, non-faulting store.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = word_idx;
    wr_data = st_data;
    wr_mask = st_mask;
    if (rst) begin
      wr_en = 1'b0;
    end else if (state_q == StInit) begin
      wr_en   = 1'b1;
      wr_idx  = init_idx_q;
      wr_data = 32'h0;
      wr_mask = 32'hFFFF_FFFF;
    end else begin
      wr_en = accept & bus.req_we & ~fault;
    end
  end

  // Memory array write; contents are cleared by INIT rather than by reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= (mem_q[wr_idx] & ~wr_mask) | (wr_data & wr_mask);
    end
  end

  // Response pipeline next state: stage 0 captures the acceptance-cycle result.
  always_comb begin
    pv_d = '0;
    pf_d = '0;
    for (int i = 0; i < int'(READ_LAT); i++) begin
      prd_d[i] = 32'h0;
    end
    pv_d[0]  = accept;
    pf_d[0]  = accept & fault;
    prd_d[0] = s0_rdata;
    for (int i = 1; i < int'(READ_LAT); i++) begin
      pv_d[i]  = pv_q[i-1];
      pf_d[i]  = pf_q[i-1];
      prd_d[i] = prd_q[i-1];
    end
  end

  // Response pipeline registers; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      pv_q <= '0;
      pf_q <= '0;
      for (int i = 0; i < int'(READ_LAT); i++) begin
        prd_q[i] <= 32'h0;
      end
    end else begin
      pv_q <= pv_d;
      pf_q <= pf_d;
      for (int i = 0; i < int'(READ_LAT); i++) begin
        prd_q[i] <= prd_d[i];
      end
    end
  end

  // Saturating fault counter next state.
  always_comb begin
    fault_cnt_d = fault_cnt_q;
    if (accept && fault && !(&fault_cnt_q)) begin
      fault_cnt_d = fault_cnt_q + 1'b1;
    end
  end

  // Fault counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_cnt_q <= '0;
    end else begin
      fault_cnt_q <= fault_cnt_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = pv_q[READ_LAT-1];
  assign bus.rsp_fault = pf_q[READ_LAT-1];
  assign bus.rsp_rdata = prd_q[READ_LAT-1];
  assign fault_cnt     = fault_cnt_q;

endmodule

// File: tb/tb_dmem_pipe.sv
// Directed bench for dmem_pipe: one READ_LAT=1 and one READ_LAT=3 instance
// driven by the same request stream.
module tb_dmem_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        v   = 1'b0;
  logic        we  = 1'b0;
  logic [2:0]  f3  = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wd   = 32'h0;
  logic [7:0]  fc1, fc3;

  int checks = 0;
  int errors = 0;

  dmem_pipe_if if1 ();
  dmem_pipe_if if3 ();

  assign if1.req_valid  = v;
  assign if1.req_we     = we;
  assign if1.req_funct3 = f3;
  assign if1.req_addr   = addr;
  assign if1.req_wdata  = wd;
  assign if3.req_valid  = v;
  assign if3.req_we     = we;
  assign if3.req_funct3 = f3;
  assign if3.req_addr   = addr;
  assign if3.req_wdata  = wd;

  dmem_pipe #(.DEPTH(64), .READ_LAT(1), .FCNT_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .bus(if1), .fault_cnt(fc1)
  );
  dmem_pipe #(.DEPTH(64), .READ_LAT(3), .FCNT_W(8)) u_dut3 (
    .clk(clk), .rst(rst), .bus(if3), .fault_cnt(fc3)
  );

  // Burst stimulus and captured responses (k = cycles after first accept edge).
  logic        b_we [4];
  logic [2:0]  b_f3 [4];
  logic [31:0] b_ad [4];
  logic [31:0] b_wd [4];
  int          n1, n3;
  int          k1 [8];
  int          k3 [8];
  logic [31:0] d1 [8];
  logic [31:0] d3 [8];
  logic        fl1 [8];
  logic        fl3 [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic burst(input int n);
    n1 = 0;
    n3 = 0;
    for (int i = 0; i < 8; i++) begin
      k1[i] = 0; k3[i] = 0; d1[i] = 32'h0; d3[i] = 32'h0; fl1[i] = 1'b0; fl3[i] = 1'b0;
    end
    v = 1'b1; we = b_we[0]; f3 = b_f3[0]; addr = b_ad[0]; wd = b_wd[0];
    for (int k = 1; k <= 8; k++) begin
      step();
      if (if1.rsp_valid === 1'b1 && n1 < 8) begin
        k1[n1] = k; d1[n1] = if1.rsp_rdata; fl1[n1] = if1.rsp_fault; n1++;
      end
      if (if3.rsp_valid === 1'b1 && n3 < 8) begin
        k3[n3] = k; d3[n3] = if3.rsp_rdata; fl3[n3] = if3.rsp_fault; n3++;
      end
      if (k < n) begin
        we = b_we[k]; f3 = b_f3[k]; addr = b_ad[k]; wd = b_wd[k];
      end else begin
        v = 1'b0;
      end
    end
  endtask

  task automatic single(input string tag, input logic swe, input logic [2:0] sf3,
                        input logic [31:0] sad, input logic [31:0] swd,
                        input logic [31:0] exp_d, input logic exp_f);
    b_we[0] = swe; b_f3[0] = sf3; b_ad[0] = sad; b_wd[0] = swd;
    burst(1);
    chk({tag, ".n1"}, n1, 1);
    chk({tag, ".n3"}, n3, 1);
    chk({tag, ".lat1"}, k1[0], 1);
    chk({tag, ".lat3"}, k3[0], 3);
    chk({tag, ".d1"}, d1[0], exp_d);
    chk({tag, ".d3"}, d3[0], exp_d);
    chk({tag, ".f1"}, fl1[0], exp_f);
    chk({tag, ".f3"}, fl3[0], exp_f);
  endtask

  // Holds rst for two edges, checks reset outputs, then measures INIT length.
  task automatic do_reset(input string tag);
    int c1, c3;
    logic seen;
    seen = 1'b0;
    rst = 1'b1;
    v = 1'b0;
    step();
    if (if1.rsp_valid !== 1'b0 || if3.rsp_valid !== 1'b0) seen = 1'b1;
    step();
    if (if1.rsp_valid !== 1'b0 || if3.rsp_valid !== 1'b0) seen = 1'b1;
    chk({tag, ".ready1"}, if1.req_ready, 0);
    chk({tag, ".ready3"}, if3.req_ready, 0);
    chk({tag, ".rdata3"}, if3.rsp_rdata, 0);
    chk({tag, ".fault3"}, if3.rsp_fault, 0);
    chk({tag, ".fcnt1"}, fc1, 0);
    chk({tag, ".fcnt3"}, fc3, 0);
    rst = 1'b0;
    c1 = -1;
    c3 = -1;
    for (int cnt = 0; cnt < 200; cnt++) begin
      if (if1.rsp_valid !== 1'b0 || if3.rsp_valid !== 1'b0) seen = 1'b1;
      if (c1 < 0 && if1.req_ready === 1'b1) c1 = cnt;
      if (c3 < 0 && if3.req_ready === 1'b1) c3 = cnt;
      if (c1 >= 0 && c3 >= 0) break;
      step();
    end
    chk({tag, ".init1"}, c1, 64);
    chk({tag, ".init3"}, c3, 64);
    chk({tag, ".norsp"}, seen, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    do_reset("por");

    // Cleared memory, including the last word.
    single("lw0",  1'b0, 3'b010, 32'h00, 32'h0, 32'h0, 1'b0);
    single("lw7c", 1'b0, 3'b010, 32'h7C, 32'h0, 32'h0, 1'b0);
    single("lwfc", 1'b0, 3'b010, 32'hFC, 32'h0, 32'h0, 1'b0);

    // Load extension.
    single("sw10",  1'b1, 3'b010, 32'h10, 32'h80FF7F01, 32'h0, 1'b0);
    single("lb10",  1'b0, 3'b000, 32'h10, 32'h0, 32'h00000001, 1'b0);
    single("lb11",  1'b0, 3'b000, 32'h11, 32'h0, 32'h0000007F, 1'b0);
    single("lb12",  1'b0, 3'b000, 32'h12, 32'h0, 32'hFFFFFFFF, 1'b0);
    single("lb13",  1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0);
    single("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0);
    single("lh12",  1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF80FF, 1'b0);
    single("lhu12", 1'b0, 3'b101, 32'h12, 32'h0, 32'h000080FF, 1'b0);

    // Partial stores leave other bytes intact.
    single("sw20",  1'b1, 3'b010, 32'h20, 32'h11223344, 32'h0, 1'b0);
    single("sb21",  1'b1, 3'b000, 32'h21, 32'hFFFFFFAB, 32'h0, 1'b0);
    single("lw20a", 1'b0, 3'b010, 32'h20, 32'h0, 32'h1122AB44, 1'b0);
    single("sh22",  1'b1, 3'b001, 32'h22, 32'h1234BEEF, 32'h0, 1'b0);
    single("lw20b", 1'b0, 3'b010, 32'h20, 32'h0, 32'hBEEFAB44, 1'b0);

    // Back-to-back loads.
    single("sw0", 1'b1, 3'b010, 32'h0, 32'h000000A0, 32'h0, 1'b0);
    single("sw4", 1'b1, 3'b010, 32'h4, 32'h000000A4, 32'h0, 1'b0);
    single("sw8", 1'b1, 3'b010, 32'h8, 32'h000000A8, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      b_we[i] = 1'b0; b_f3[i] = 3'b010; b_ad[i] = 32'(i * 4); b_wd[i] = 32'h0;
    end
    burst(3);
    chk("b2b.n3", n3, 3);
    chk("b2b.k3_0", k3[0], 3);
    chk("b2b.k3_1", k3[1], 4);
    chk("b2b.k3_2", k3[2], 5);
    chk("b2b.d3_0", d3[0], 32'hA0);
    chk("b2b.d3_1", d3[1], 32'hA4);
    chk("b2b.d3_2", d3[2], 32'hA8);
    chk("b2b.n1", n1, 3);
    chk("b2b.k1_2", k1[2], 3);
    chk("b2b.d1_1", d1[1], 32'hA4);

    // Load right after a store to the same word.
    b_we[0] = 1'b1; b_f3[0] = 3'b010; b_ad[0] = 32'h30; b_wd[0] = 32'hCAFEF00D;
    b_we[1] = 1'b0; b_f3[1] = 3'b010; b_ad[1] = 32'h30; b_wd[1] = 32'h0;
    burst(2);
    chk("raw.d1_0", d1[0], 32'h0);
    chk("raw.d1_1", d1[1], 32'hCAFEF00D);
    chk("raw.d3_1", d3[1], 32'hCAFEF00D);
    chk("raw.k3_1", k3[1], 4);

    // Faults.
    single("mis102", 1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 1'b1);
    single("oor100", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1'b1);
    single("f3_011", 1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1);
    chk("fcnt3.dut1", fc1, 3);
    chk("fcnt3.dut3", fc3, 3);
    single("lw0keep", 1'b0, 3'b010, 32'h0, 32'h0, 32'h000000A0, 1'b0);
    single("shodd",   1'b1, 3'b001, 32'h21, 32'h5555, 32'h0, 1'b1);
    single("lw20c",   1'b0, 3'b010, 32'h20, 32'h0, 32'hBEEFAB44, 1'b0);
    single("sbu",     1'b1, 3'b100, 32'h20, 32'h77, 32'h0, 1'b1);
    single("lw20d",   1'b0, 3'b010, 32'h20, 32'h0, 32'hBEEFAB44, 1'b0);

    // Saturation.
    v = 1'b1; we = 1'b0; f3 = 3'b011; addr = 32'h0; wd = 32'h0;
    repeat (300) step();
    v = 1'b0;
    repeat (5) step();
    chk("fsat.dut1", fc1, 255);
    chk("fsat.dut3", fc3, 255);

    // Reset with two loads in flight.
    single("sw40", 1'b1, 3'b010, 32'h40, 32'h5555AAAA, 32'h0, 1'b0);
    v = 1'b1; we = 1'b0; f3 = 3'b010; addr = 32'h40;
    step();
    addr = 32'h44;
    step();
    chk("inflight.pre", if3.rsp_valid, 0);
    do_reset("rerst");
    single("lw40", 1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_pipe.md
Name: dmem_pipe

Overview:
- Parametrised successor to the single-port data memory.
- Word-organised RAM with a valid/ready request interface and a configurable read pipeline (READ_LAT cycles).
- Handles funct3-encoded byte/half/word loads and stores, with sign or zero extension on loads.
- Flags misaligned, out-of-range and illegal accesses; clears itself word-by-word after reset; keeps a saturating fault counter.
- Sits between the core's MEM stage and the data RAM.

Parameters:
- DEPTH, 64, number of 32-bit words; power of two, 4..4096.
- READ_LAT, 1, cycles from request acceptance to response; legal 1..4.
- FCNT_W, 8, width of the saturating fault counter.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  access type: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; right-aligned.
- rsp_valid  out  1  response valid; exactly one per accepted request.
- rsp_rdata  out  32  extended load data; 0 for stores and faults.
- rsp_fault  out  1  accepted request faulted; no memory update.
- fault_cnt  out  FCNT_W  saturating count of faulted requests.

Behaviour:
- One clock (clk). Reset rst is synchronous and active-high; it is sampled only on the posedge.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_fault=0, fault_cnt=0.
- Reset also empties the response pipeline; in-flight requests are dropped without responses.
- FSM INIT: entered on reset.
  - Writes 0 to word init_idx, one word per cycle, init_idx 0..DEPTH-1.
  - req_ready=0 throughout.
  - After writing word DEPTH-1, moves to RUN. INIT lasts exactly DEPTH cycles after rst deasserts.
- FSM RUN: req_ready=1 every cycle. Accept = req_valid & req_ready. The only exit is rst.
- Reset mid-INIT or mid-RUN restarts INIT at word 0.
- Accepted requests are ordered. Up to READ_LAT requests can be in flight, one per cycle; there is no response backpressure.
- Response for a request accepted at edge N appears with rsp_valid=1 during the cycle after edge N+READ_LAT-1. READ_LAT=1 means the response is valid the cycle after acceptance.
- Array read and all fault decode happen in the acceptance cycle; the result then passes through READ_LAT-1 register stages.
- Fault decode (any condition faults the request):
  - word index req_addr[31:2] >= DEPTH;
  - h/hu with addr[0]=1;
  - w with addr[1:0]!=0;
  - store funct3 not in {000,001,010};
  - load funct3 in {011,110,111}.
- On a fault: no array write, rsp_fault=1, rsp_rdata=0. fault_cnt increments when the faulting request is accepted and saturates at all-ones without wrapping.
- Stores write at the acceptance edge.
  - sb: lane addr[1:0] gets wdata[7:0].
  - sh: lanes addr[1] (low or high half) get wdata[15:0].
  - sw: all 32 bits.
  - Unselected bytes are unchanged. A store response has rsp_fault=0 and rsp_rdata=0.
- Loads select lane by addr[1:0] or addr[1].
  - b/h: sign-extend from bit 7/15.
  - bu/hu: zero-extend.
  - w: full word.
- Read-after-write: a load accepted the cycle after a store to the same word returns the new data; no forwarding is needed because the write commits at the acceptance edge.
- rsp_rdata and rsp_fault are 0 whenever rsp_valid=0.

Test Plan:
- Reset, DEPTH=64 -> req_ready stays 0 for exactly 64 cycles after rst falls, then 1; lw of addr 0x00, 0x7C and 0xFC (last word) -> rdata 0x00000000, fault 0.
- sw 0x80FF7F01 @0x10, then lb @0x10/0x11/0x12/0x13 -> 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80; lbu @0x13 -> 0x00000080; lh @0x12 -> 0xFFFF80FF; lhu @0x12 -> 0x000080FF.
- sb 0xAB @0x21 onto word 0x11223344 at 0x20 -> lw @0x20 = 0x1122AB44; sh 0xBEEF @0x22 -> lw = 0xBEEFAB44.
- READ_LAT=3, back-to-back loads @0x0,0x4,0x8 accepted on consecutive edges -> three rsp_valid pulses on consecutive cycles, in order, the first exactly 3 cycles after the first accept.
- lw @0x102 (misaligned), sw @0x100 with DEPTH=64 (out of range), load funct3=011 -> rsp_fault=1, rdata=0, memory unchanged, fault_cnt=3; 300 faults with FCNT_W=8 -> fault_cnt holds 255.
- rst asserted with 2 loads in flight (READ_LAT=3) -> no rsp_valid afterward for them; INIT reruns; a word written before the reset reads 0.
